cart_load_ctrl: RTL and testbench

Sequences a cartridge image download from the HPS ioctl stream into the cart DPRAM write port and parses the optional 128-byte A78 header. It produces cart size, flags and region, and holds the console core in reset until the image is committed and a settle interval has elapsed. It sits between hps_io and the cart memory and feeds cart_size, cart_flags, cart_region and the core reset term of the top level.

---
 rtl/cart_load_pkg.sv | 21 ++
 rtl/cart_load_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_cart_load_ctrl.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cart_load_pkg.sv
// Shared types and header offsets for the cartridge loader.
package cart_load_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_COMMIT,
      ST_SETTLE,
      ST_READY
   } state_e;

   // A78 signature, bytes 1..5 of the file; byte 1 ends up in the MSBs
   localparam logic [39:0] HDR_SIG = "ATARI";

   localparam int SIG_FIRST = 1;
   localparam int SIG_LAST  = 5;
   localparam int FLAG_HI   = 53;
   localparam int FLAG_LO   = 54;
   localparam int REGION    = 57;

endpackage

// File: rtl/cart_load_ctrl.sv
// Cartridge download sequencer: maps ioctl bytes into cart DPRAM, parses the
// optional A78 header and keeps the core in reset until the image settles.
module cart_load_ctrl
   import cart_load_pkg::*;
#(
   parameter int ADDR_W     = 18,
   parameter int HDR_LEN    = 128,
   parameter int SETTLE_CYC = 16
) (
   input  logic              clk_sys,
   input  logic              reset_n,
   input  logic              dl_active,
   input  logic              dl_wr,
   input  logic [24:0]       dl_addr,
   input  logic [7:0]        dl_data,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_data,
   output logic              mem_we,
   output logic              cart_is_7800,
   output logic [31:0]       cart_size,
   output logic [15:0]       cart_flags,
   output logic              cart_region,
   output logic              overflow,
   output logic              load_done,
   output logic              sys_hold
);

   localparam int          CNT_W  = $clog2(SETTLE_CYC + 1);
   localparam logic [24:0] HDR_A  = 25'(HDR_LEN);
   localparam logic [31:0] HDR_32 = 32'(HDR_LEN);

   state_e state_q, state_d;

   logic              act_q;
   logic [39:0]       sig_q, sig_d;
   logic [7:0]        fhi_q, fhi_d, flo_q, flo_d;
   logic              rgn_q, rgn_d;
   logic [24:0]       max_q, max_d;
   logic              seen_q, seen_d;
   logic              ovf_q, ovf_d;
   logic [ADDR_W-1:0] maddr_q, maddr_d;
   logic [7:0]        mdata_q, mdata_d;
   logic              mwe_q, mwe_d;
   logic              is78_q, is78_d;
   logic [31:0]       size_q, size_d;
   logic [15:0]       flags_q, flags_d;
   logic              creg_q, creg_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic              rise, fall, accept, sig_ok, sig_now;
   logic [24:0]       map_addr;
   logic [31:0]       size_raw;

   assign rise   = dl_active & ~act_q;
   assign fall   = ~dl_active & act_q;
   assign accept = dl_active & dl_wr;
   // Mapping decision uses the registered signature; a rise clears it first
   assign sig_ok  = (sig_q == HDR_SIG) & ~rise;
   assign sig_now = (sig_q == HDR_SIG);

   // State register
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   // Next state: any dl_active rise restarts the load, aborting commit/settle
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   state_d = ST_IDLE;
         ST_LOAD:   if (fall) state_d = ST_COMMIT;
         ST_COMMIT: state_d = ST_SETTLE;
         ST_SETTLE: if (cnt_q == '0) state_d = ST_READY;
         ST_READY:  state_d = ST_READY;
         default:   state_d = ST_IDLE;
      endcase
      if (rise) state_d = ST_LOAD;
   end

   // FSM outputs: the core only runs once the image has settled
   always_comb begin
      load_done = (state_q == ST_READY);
      sys_hold  = (state_q != ST_READY);
   end

   // Datapath: staging capture, write mapping, commit results, settle count
   always_comb begin
      sig_d    = sig_q;
      fhi_d    = fhi_q;
      flo_d    = flo_q;
      rgn_d    = rgn_q;
      max_d    = max_q;
      seen_d   = seen_q;
      ovf_d    = ovf_q;
      maddr_d  = maddr_q;
      mdata_d  = mdata_q;
      mwe_d    = 1'b0;
      is78_d   = is78_q;
      size_d   = size_q;
      flags_d  = flags_q;
      creg_d   = creg_q;
      cnt_d    = cnt_q;
      map_addr = dl_addr;
      size_raw = {7'd0, max_q} + 32'd1;

      if (rise) begin
         sig_d  = '0;
         fhi_d  = '0;
         flo_d  = '0;
         rgn_d  = 1'b0;
         max_d  = '0;
         seen_d = 1'b0;
         ovf_d  = 1'b0;
      end

      if (accept) begin
         if (dl_addr >= 25'(SIG_FIRST) && dl_addr <= 25'(SIG_LAST))
            sig_d = {sig_d[31:0], dl_data};
         if (dl_addr == 25'(FLAG_HI)) fhi_d = dl_data;
         if (dl_addr == 25'(FLAG_LO)) flo_d = dl_data;
         if (dl_addr == 25'(REGION))  rgn_d = dl_data[0];
         if (dl_addr > max_d) max_d = dl_addr;
         seen_d = 1'b1;

         // Header bytes go raw and get overwritten by the body on purpose
         if (dl_addr >= HDR_A && sig_ok) map_addr = dl_addr - HDR_A;
         if (|map_addr[24:ADDR_W]) begin
            ovf_d = 1'b1;
         end else begin
            mwe_d   = 1'b1;
            maddr_d = map_addr[ADDR_W-1:0];
            mdata_d = dl_data;
         end
      end

      if (state_q == ST_COMMIT && !rise) begin
         is78_d  = sig_now;
         flags_d = sig_now ? {fhi_q, flo_q} : 16'd0;
         creg_d  = sig_now & rgn_q;
         if (!seen_q)                           size_d = '0;
         else if (!sig_now)                     size_d = size_raw;
         else if (size_raw < HDR_32)            size_d = '0;
         else                                   size_d = size_raw - HDR_32;
      end

      if (state_q == ST_COMMIT)                        cnt_d = CNT_W'(SETTLE_CYC - 1);
      else if (state_q == ST_SETTLE && cnt_q != '0)    cnt_d = cnt_q - 1'b1;
   end

   // Datapath registers
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         act_q   <= 1'b0;
         sig_q   <= '0;
         fhi_q   <= '0;
         flo_q   <= '0;
         rgn_q   <= 1'b0;
         max_q   <= '0;
         seen_q  <= 1'b0;
         ovf_q   <= 1'b0;
         maddr_q <= '0;
         mdata_q <= '0;
         mwe_q   <= 1'b0;
         is78_q  <= 1'b0;
         size_q  <= '0;
         flags_q <= '0;
         creg_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         act_q   <= dl_active;
         sig_q   <= sig_d;
         fhi_q   <= fhi_d;
         flo_q   <= flo_d;
         rgn_q   <= rgn_d;
         max_q   <= max_d;
         seen_q  <= seen_d;
         ovf_q   <= ovf_d;
         maddr_q <= maddr_d;
         mdata_q <= mdata_d;
         mwe_q   <= mwe_d;
         is78_q  <= is78_d;
         size_q  <= size_d;
         flags_q <= flags_d;
         creg_q  <= creg_d;
         cnt_q   <= cnt_d;
      end
   end

   assign mem_addr     = maddr_q;
   assign mem_data     = mdata_q;
   assign mem_we       = mwe_q;
   assign cart_is_7800 = is78_q;
   assign cart_size    = size_q;
   assign cart_flags   = flags_q;
   assign cart_region  = creg_q;
   assign overflow     = ovf_q;

endmodule

// File: tb/tb_cart_load_ctrl.sv
// Bench for cart_load_ctrl: randomized downloads against a byte-level model.
module tb_cart_load_ctrl;

   localparam int ADDR_W     = 18;
   localparam int HDR_LEN    = 128;
   localparam int SETTLE_CYC = 16;
   localparam logic [39:0] SIG = "ATARI";

   logic              clk_sys = 1'b0;
   logic              reset_n;
   logic              dl_active, dl_wr;
   logic [24:0]       dl_addr;
   logic [7:0]        dl_data;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_data;
   logic              mem_we, cart_is_7800, cart_region, overflow, load_done, sys_hold;
   logic [31:0]       cart_size;
   logic [15:0]       cart_flags;

   int n_tests = 0;
   int n_fail  = 0;

   cart_load_ctrl #(.ADDR_W(ADDR_W), .HDR_LEN(HDR_LEN), .SETTLE_CYC(SETTLE_CYC)) dut (
      .clk_sys(clk_sys), .reset_n(reset_n), .dl_active(dl_active), .dl_wr(dl_wr),
      .dl_addr(dl_addr), .dl_data(dl_data), .mem_addr(mem_addr), .mem_data(mem_data),
      .mem_we(mem_we), .cart_is_7800(cart_is_7800), .cart_size(cart_size),
      .cart_flags(cart_flags), .cart_region(cart_region), .overflow(overflow),
      .load_done(load_done), .sys_hold(sys_hold));

   always #5 clk_sys = ~clk_sys;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Bytes by file offset for the header window, largest offset seen, and the
   // number of clock edges since the download ended (-1 while none pending).
   logic [7:0]  m_hdr [0:63];
   int          m_max, m_since;
   bit          m_seen, m_ovf, m_prev;
   bit          e_we, e_is78, e_reg;
   int          e_addr;
   logic [7:0]  e_data;
   logic [31:0] e_size;
   logic [15:0] e_flags;

   function automatic bit m_is78();
      return {m_hdr[1], m_hdr[2], m_hdr[3], m_hdr[4], m_hdr[5]} == SIG;
   endfunction

   always @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 64; i++) m_hdr[i] = 8'h00;
         m_max = 0; m_seen = 0; m_ovf = 0; m_prev = 0; m_since = -1;
         e_we = 0; e_addr = 0; e_data = 0; e_is78 = 0; e_reg = 0; e_size = 0; e_flags = 0;
      end else begin
         e_we = 0;
         if (dl_active && !m_prev) begin
            for (int i = 0; i < 64; i++) m_hdr[i] = 8'h00;
            m_max = 0; m_seen = 0; m_ovf = 0; m_since = -1;
         end
         if (dl_active && dl_wr) begin
            int a, mapped;
            a = int'(dl_addr);
            mapped = (a >= HDR_LEN && m_is78()) ? a - HDR_LEN : a;
            if (mapped >= (1 << ADDR_W)) m_ovf = 1;
            else begin e_we = 1; e_addr = mapped; e_data = dl_data; end
            if (a < 64) m_hdr[a] = dl_data;
            if (!m_seen || a > m_max) m_max = a;
            m_seen = 1;
         end
         if (!dl_active && m_prev) m_since = 0;
         else if (m_since >= 0 && m_since < 1000) m_since++;
         if (m_since == 1) begin
            int sz;
            e_is78  = m_is78();
            sz      = m_seen ? m_max + 1 - (e_is78 ? HDR_LEN : 0) : 0;
            e_size  = (sz < 0) ? 32'd0 : 32'(sz);
            e_flags = e_is78 ? {m_hdr[53], m_hdr[54]} : 16'h0;
            e_reg   = e_is78 ? m_hdr[57][0] : 1'b0;
         end
         m_prev = dl_active;
      end
   end

   // ---------------- compare + write monitor ----------------
   int         wr_cnt, max_wr;
   logic [7:0] data_at0;
   bit         saw_done;

   always @(negedge clk_sys) begin
      if (reset_n) begin
         bit e_hold;
         e_hold = !(m_since >= 1 + SETTLE_CYC);
         chk("mem_we", 32'(mem_we), 32'(e_we));
         if (e_we && mem_we) begin
            chk("mem_addr", 32'(mem_addr), 32'(e_addr));
            chk("mem_data", 32'(mem_data), 32'(e_data));
         end
         chk("overflow", 32'(overflow), 32'(m_ovf));
         chk("is_7800", 32'(cart_is_7800), 32'(e_is78));
         chk("cart_size", cart_size, e_size);
         chk("cart_flags", 32'(cart_flags), 32'(e_flags));
         chk("cart_region", 32'(cart_region), 32'(e_reg));
         chk("sys_hold", 32'(sys_hold), 32'(e_hold));
         chk("load_done", 32'(load_done), 32'(!e_hold));
         if (mem_we) begin
            wr_cnt++;
            if (int'(mem_addr) > max_wr) max_wr = int'(mem_addr);
            if (mem_addr == '0) data_at0 = mem_data;
         end
         if (load_done) saw_done = 1;
      end
   end

   // ---------------- stimulus ----------------
   logic [7:0] byte128;

   task automatic drive(input bit a, input bit w, input int ad, input logic [7:0] d);
      dl_active = a; dl_wr = w; dl_addr = 25'(ad); dl_data = d;
      @(posedge clk_sys); #2;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, 0, 0, 8'h00);
   endtask

   function automatic logic [7:0] hdr_byte(input int a, input logic [7:0] fh, input logic [7:0] fl,
                                           input logic [7:0] rg, input logic [7:0] dflt);
      logic [39:0] s;
      s = SIG;
      if (a >= 1 && a <= 5) return s[8*(5-a) +: 8];
      if (a == 53) return fh;
      if (a == 54) return fl;
      if (a == 57) return rg;
      return dflt;
   endfunction

   // Streams one image in file order, with optional random idle gaps, then drops dl_active
   task automatic load_image(input bit is78, input int body, input logic [7:0] fh,
                             input logic [7:0] fl, input logic [7:0] rg, input int gap_pct);
      int total;
      logic [7:0] d;
      total = (is78 ? HDR_LEN : 0) + body;
      for (int a = 0; a < total; a++) begin
         if (gap_pct > 0) while (int'($urandom_range(99)) < gap_pct) drive(1, 0, 0, 8'h00);
         d = 8'($urandom);
         if (is78 && a < HDR_LEN) d = hdr_byte(a, fh, fl, rg, d);
         if (!is78 && a == 1) d = 8'hFF;
         if (a == HDR_LEN) byte128 = d;
         drive(1, 1, a, d);
      end
      drive(0, 0, 0, 8'h00);
   endtask

   // Counts edges from the end of the download until sys_hold drops
   task automatic wait_ready(output int n);
      n = 0;
      while (n < 200) begin
         @(negedge clk_sys);
         if (!sys_hold) break;
         n++;
      end
      if (n >= 200) chk("ready_timeout", 32'(n), 32'(SETTLE_CYC + 1));
      #3;
   endtask

   initial begin
      int n;
      reset_n = 1'b0;
      dl_active = 0; dl_wr = 0; dl_addr = '0; dl_data = '0;
      #3;
      chk("rst_sys_hold", 32'(sys_hold), 32'd1);
      chk("rst_load_done", 32'(load_done), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_cart_size", cart_size, 32'd0);
      @(posedge clk_sys); #2;
      reset_n = 1'b1;
      idle(3);

      // 2600 image, no header, back-to-back
      wr_cnt = 0; max_wr = 0;
      load_image(0, 4096, 8'h00, 8'h00, 8'h00, 0);
      wait_ready(n);
      chk("2600_hold_latency", 32'(n), 32'(SETTLE_CYC + 1));
      chk("2600_size", cart_size, 32'd4096);
      chk("2600_is78", 32'(cart_is_7800), 32'd0);
      chk("2600_flags", 32'(cart_flags), 32'd0);
      chk("2600_wr_cnt", 32'(wr_cnt), 32'd4096);
      chk("2600_max_wr", 32'(max_wr), 32'd4095);

      // A78 image, 128 + 32768 bytes
      idle(4);
      wr_cnt = 0; max_wr = 0;
      load_image(1, 32768, 8'h00, 8'h02, 8'h01, 0);
      wait_ready(n);
      chk("a78_size", cart_size, 32'd32768);
      chk("a78_is78", 32'(cart_is_7800), 32'd1);
      chk("a78_flags", 32'(cart_flags), 32'h0002);
      chk("a78_region", 32'(cart_region), 32'd1);
      chk("a78_byte128_at0", 32'(data_at0), 32'(byte128));
      chk("a78_max_wr", 32'(max_wr), 32'h7FFF);

      // Random images with random gaps and header contents
      for (int k = 0; k < 5; k++) begin
         idle(int'($urandom_range(1, 6)));
         load_image(1'($urandom), int'($urandom_range(0, 700)), 8'($urandom), 8'($urandom),
                    8'($urandom), 30);
         wait_ready(n);
         chk("rnd_hold_latency", 32'(n), 32'(SETTLE_CYC + 1));
      end

      // Sparse A78 image to 128+300000 bytes: overflow beyond 256 KiB
      idle(3);
      max_wr = 0;
      for (int a = 0; a < HDR_LEN; a++)
         drive(1, 1, a, hdr_byte(a, 8'h12, 8'h34, 8'h00, 8'($urandom)));
      drive(1, 1, HDR_LEN + 32'h3FFFE, 8'hA1);
      drive(1, 1, HDR_LEN + 32'h3FFFF, 8'hA2);
      drive(1, 1, HDR_LEN + 32'h40000, 8'hA3);
      drive(1, 1, HDR_LEN + 299999, 8'hA4);
      drive(0, 0, 0, 8'h00);
      wait_ready(n);
      chk("ovf_flag", 32'(overflow), 32'd1);
      chk("ovf_max_wr", 32'(max_wr), 32'h3FFFF);
      chk("ovf_size", cart_size, 32'd300000);
      chk("ovf_load_done", 32'(load_done), 32'd1);

      // Second download started during settle
      idle(2);
      load_image(0, 200, 8'h00, 8'h00, 8'h00, 0);
      saw_done = 0;
      idle(5);
      load_image(1, 64, 8'h80, 8'h01, 8'h00, 10);
      chk("abort_no_done", 32'(saw_done), 32'd0);
      wait_ready(n);
      chk("abort_size", cart_size, 32'd64);
      chk("abort_flags", 32'(cart_flags), 32'h8001);

      // Reset mid-load: immediate reset values, nothing committed
      idle(2);
      for (int a = 0; a < 50; a++) drive(1, 1, a, 8'($urandom));
      reset_n = 1'b0; dl_active = 0; dl_wr = 0;
      @(negedge clk_sys);
      chk("rst_mid_hold", 32'(sys_hold), 32'd1);
      chk("rst_mid_size", cart_size, 32'd0);
      chk("rst_mid_is78", 32'(cart_is_7800), 32'd0);
      chk("rst_mid_we", 32'(mem_we), 32'd0);
      @(posedge clk_sys); #2;
      reset_n = 1'b1;
      saw_done = 0;
      idle(40);
      chk("rst_no_commit", 32'(saw_done), 32'd0);

      // dl_active pulse with no writes
      drive(1, 0, 0, 8'h00);
      drive(1, 0, 0, 8'h00);
      drive(1, 0, 0, 8'h00);
      drive(0, 0, 0, 8'h00);
      wait_ready(n);
      chk("empty_size", cart_size, 32'd0);
      chk("empty_is78", 32'(cart_is_7800), 32'd0);
      chk("empty_done", 32'(load_done), 32'd1);

      // Header-only A78 image: size clamps to zero
      idle(2);
      load_image(1, 0, 8'h00, 8'h00, 8'h01, 0);
      wait_ready(n);
      chk("hdr_only_size", cart_size, 32'd0);
      chk("hdr_only_is78", 32'(cart_is_7800), 32'd1);

      idle(3);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
